// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding / hazard controller.
// Forward-select encoding, multi-cycle FSM states and the hard-wired zero register.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_ME = 2'b10,
      FWD_WB = 2'b11
   } fwd_sel_t;

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;

   localparam logic [31:0] REG_X0 = '0;
   localparam int          CNT_W  = 4;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator: picks ME, then WB, then the register file.
// A destination of x0 never forwards, since x0 always reads as zero.
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
)(
   input  logic              wr_me,
   input  logic [REG_AW-1:0] rd_me,
   input  logic              wr_wb,
   input  logic [REG_AW-1:0] rd_wb,
   input  logic [REG_AW-1:0] rs,
   output fwd_sel_t          sel
);

   always_comb begin
      sel = FWD_RF;
      if (wr_me && (rd_me != REG_AW'(REG_X0)) && (rd_me == rs))
         sel = FWD_ME;
      else if (wr_wb && (rd_wb != REG_AW'(REG_X0)) && (rd_wb == rs))
         sel = FWD_WB;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage core: operand forward selects,
// load-use stall, and a counter-driven stall FSM for multi-cycle EX operations.
module fwd_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int MC_LAT  = 4
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      RUWr_ex,
   input  logic                      load_ex,
   input  logic [REG_AW-1:0]         rd_ex,
   input  logic                      mc_start_ex,
   input  logic                      RUWr_me,
   input  logic [REG_AW-1:0]         rd_me,
   input  logic                      RUWr_wb,
   input  logic [REG_AW-1:0]         rd_wb,
   input  logic [NUM_SRC*REG_AW-1:0] rs_id,
   input  logic [NUM_SRC*REG_AW-1:0] rs_ex,
   input  logic                      flush,
   output logic [NUM_SRC*2-1:0]      FUSrc,
   output logic                      stall_pc,
   output logic                      stall_ifid,
   output logic                      stall_idex,
   output logic                      bubble_ex,
   output logic                      bubble_me,
   output logic                      mc_busy,
   output logic                      mc_done
);

   localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 2);

   mc_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   fwd_sel_t         fwd_raw [NUM_SRC];
   logic             rs_hit, lu, mc_stall;
   logic             s_pc, s_ifid, s_idex, b_ex, b_me, done;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
         .wr_me (RUWr_me),
         .rd_me (rd_me),
         .wr_wb (RUWr_wb),
         .rd_wb (rd_wb),
         .rs    (rs_ex[i*REG_AW +: REG_AW]),
         .sel   (fwd_raw[i])
      );
      assign FUSrc[2*i +: 2] = rst ? 2'b00 : fwd_raw[i];
   end

   always_comb begin
      rs_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (rs_id[i*REG_AW +: REG_AW] == rd_ex)
            rs_hit = 1'b1;
   end

   assign lu = load_ex && RUWr_ex && (rd_ex != REG_AW'(REG_X0)) && rs_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MC_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Flush overrides everything; otherwise a multi-cycle stall masks load-use.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      mc_stall = 1'b0;
      done     = 1'b0;
      s_pc     = 1'b0;
      s_ifid   = 1'b0;
      s_idex   = 1'b0;
      b_ex     = 1'b0;
      b_me     = 1'b0;
      if (flush) begin
         state_n = MC_IDLE;
         cnt_n   = '0;
         b_ex    = 1'b1;
         b_me    = 1'b1;
      end else begin
         case (state)
            MC_IDLE: begin
               if (mc_start_ex) begin
                  mc_stall = 1'b1;
                  cnt_n    = MC_LOAD;
                  state_n  = MC_BUSY;
               end
            end
            MC_BUSY: begin
               if (cnt != '0) begin
                  mc_stall = 1'b1;
                  cnt_n    = cnt - CNT_W'(1);
               end else begin
                  done    = 1'b1;
                  state_n = MC_IDLE;
               end
            end
            default: state_n = MC_IDLE;
         endcase
         if (mc_stall) begin
            s_pc   = 1'b1;
            s_ifid = 1'b1;
            s_idex = 1'b1;
            b_me   = 1'b1;
         end else if (lu) begin
            s_pc   = 1'b1;
            s_ifid = 1'b1;
            b_ex   = 1'b1;
         end
      end
   end

   assign stall_pc   = s_pc   & ~rst;
   assign stall_ifid = s_ifid & ~rst;
   assign stall_idex = s_idex & ~rst;
   assign bubble_ex  = b_ex   & ~rst;
   assign bubble_me  = b_me   & ~rst;
   assign mc_done    = done   & ~rst;
   assign mc_busy    = (state == MC_BUSY) & ~rst;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed vector table, hand-written
// multi-cycle/flush/reset sequences, then random stimulus against a reference model.
module tb_fwd_hazard_ctrl;

   localparam int REG_AW  = 5;
   localparam int NUM_SRC = 2;
   localparam int MC_LAT  = 4;

   typedef struct packed {
      logic        rst;
      logic        ruwrEx;
      logic        loadEx;
      logic [4:0]  rdEx;
      logic        mcStart;
      logic        ruwrMe;
      logic [4:0]  rdMe;
      logic        ruwrWb;
      logic [4:0]  rdWb;
      logic [9:0]  rsId;
      logic [9:0]  rsEx;
      logic        flush;
   } inVec_t;

   // ctl order: stall_pc, stall_ifid, stall_idex, bubble_ex, bubble_me, mc_busy, mc_done
   typedef struct {
      inVec_t     in;
      logic [3:0] fu;
      logic [6:0] ctl;
   } tblVec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RUWr_ex = 1'b0, load_ex = 1'b0, mc_start_ex = 1'b0;
   logic        RUWr_me = 1'b0, RUWr_wb = 1'b0, flush = 1'b0;
   logic [4:0]  rd_ex = '0, rd_me = '0, rd_wb = '0;
   logic [9:0]  rs_id = '0, rs_ex = '0;
   logic [3:0]  FUSrc;
   logic        stall_pc, stall_ifid, stall_idex, bubble_ex, bubble_me, mc_busy, mc_done;

   int vecCount  = 0;
   int missCount = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MC_LAT(MC_LAT)) dut (
      .clk         (clk),
      .rst         (rst),
      .RUWr_ex     (RUWr_ex),
      .load_ex     (load_ex),
      .rd_ex       (rd_ex),
      .mc_start_ex (mc_start_ex),
      .RUWr_me     (RUWr_me),
      .rd_me       (rd_me),
      .RUWr_wb     (RUWr_wb),
      .rd_wb       (rd_wb),
      .rs_id       (rs_id),
      .rs_ex       (rs_ex),
      .flush       (flush),
      .FUSrc       (FUSrc),
      .stall_pc    (stall_pc),
      .stall_ifid  (stall_ifid),
      .stall_idex  (stall_idex),
      .bubble_ex   (bubble_ex),
      .bubble_me   (bubble_me),
      .mc_busy     (mc_busy),
      .mc_done     (mc_done)
   );

   task automatic applyStimulus(input inVec_t v);
      rst         = v.rst;
      RUWr_ex     = v.ruwrEx;
      load_ex     = v.loadEx;
      rd_ex       = v.rdEx;
      mc_start_ex = v.mcStart;
      RUWr_me     = v.ruwrMe;
      rd_me       = v.rdMe;
      RUWr_wb     = v.ruwrWb;
      rd_wb       = v.rdWb;
      rs_id       = v.rsId;
      rs_ex       = v.rsEx;
      flush       = v.flush;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] fuExp, input logic [6:0] ctlExp);
      logic [6:0] ctlAct;
      ctlAct = {stall_pc, stall_ifid, stall_idex, bubble_ex, bubble_me, mc_busy, mc_done};
      vecCount++;
      if (FUSrc !== fuExp || ctlAct !== ctlExp) begin
         missCount++;
         $display("[TB] FAIL %s: got FUSrc=%b ctl=%b, expected FUSrc=%b ctl=%b",
                  name, FUSrc, ctlAct, fuExp, ctlExp);
      end
   endtask

   // One cycle: drive at the falling edge, sample shortly after.
   task automatic stepCheck(input string name, input inVec_t v, input logic [3:0] fuExp,
                            input logic [6:0] ctlExp);
      @(negedge clk);
      applyStimulus(v);
      #1;
      checkOutput(name, fuExp, ctlExp);
   endtask

   // Reference forwarding: for each operand, ME wins over WB, x0 never forwards.
   function automatic logic [3:0] modelFwd(input inVec_t v);
      logic [3:0] r;
      int src;
      r = '0;
      if (v.rst) return r;
      for (int i = 0; i < NUM_SRC; i++) begin
         src = int'(v.rsEx[i*REG_AW +: REG_AW]);
         if (v.ruwrMe && int'(v.rdMe) != 0 && int'(v.rdMe) == src)
            r[2*i +: 2] = 2'b10;
         else if (v.ruwrWb && int'(v.rdWb) != 0 && int'(v.rdWb) == src)
            r[2*i +: 2] = 2'b11;
      end
      return r;
   endfunction

   function automatic bit modelLu(input inVec_t v);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++)
         if (int'(v.rsId[i*REG_AW +: REG_AW]) == int'(v.rdEx)) hit = 1'b1;
      return v.loadEx && v.ruwrEx && int'(v.rdEx) != 0 && hit;
   endfunction

   // k = cycles elapsed since the multi-cycle op entered EX (0 when idle).
   function automatic logic [6:0] modelCtl(input inVec_t v, input int k);
      bit busy, stallMc, done;
      if (v.rst) return 7'b0;
      busy = (k != 0);
      if (v.flush) return {3'b000, 1'b1, 1'b1, busy, 1'b0};
      stallMc = (k == 0 && v.mcStart) || (k > 0 && k < MC_LAT - 1);
      done    = (k == MC_LAT - 1);
      if (stallMc)       return {3'b111, 1'b0, 1'b1, busy, 1'b0};
      else if (modelLu(v)) return {3'b110, 1'b1, 1'b0, busy, done};
      else               return {5'b00000, busy, done};
   endfunction

   function automatic int modelNextK(input inVec_t v, input int k);
      if (v.rst || v.flush) return 0;
      if (k == 0) return v.mcStart ? 1 : 0;
      if (k < MC_LAT - 1) return k + 1;
      return 0;
   endfunction

   tblVec_t tbl [12];
   inVec_t  v;
   int      k;

   initial begin
      // Reset with forwarding and hazard inputs active: everything must read zero.
      v = '0;
      v.rst = 1'b1; v.ruwrMe = 1'b1; v.rdMe = 5'd5; v.rsEx = {5'd5, 5'd5};
      v.flush = 1'b1; v.mcStart = 1'b1;
      stepCheck("reset_outputs", v, 4'b0000, 7'b0);
      repeat (2) @(posedge clk);
      v = '0;
      stepCheck("after_reset", v, 4'b0000, 7'b0);

      v = '0; v.ruwrMe = 1; v.rdMe = 5'd5; v.ruwrWb = 1; v.rdWb = 5'd5; v.rsEx = {5'd5, 5'd5};
      tbl[0] = '{in: v, fu: 4'b1010, ctl: 7'b0};
      v.rdMe = 5'd7;
      tbl[1] = '{in: v, fu: 4'b1111, ctl: 7'b0};
      v = '0; v.ruwrMe = 1; v.rdMe = 5'd0; v.rsEx = {5'd0, 5'd3};
      tbl[2] = '{in: v, fu: 4'b0000, ctl: 7'b0};
      v = '0; v.ruwrWb = 1; v.rdWb = 5'd0; v.rsEx = {5'd0, 5'd0};
      tbl[3] = '{in: v, fu: 4'b0000, ctl: 7'b0};
      v = '0; v.ruwrMe = 1; v.rdMe = 5'd3; v.ruwrWb = 1; v.rdWb = 5'd4; v.rsEx = {5'd4, 5'd3};
      tbl[4] = '{in: v, fu: 4'b1110, ctl: 7'b0};
      v = '0; v.ruwrMe = 0; v.rdMe = 5'd3; v.rsEx = {5'd3, 5'd3};
      tbl[5] = '{in: v, fu: 4'b0000, ctl: 7'b0};
      v = '0; v.loadEx = 1; v.ruwrEx = 1; v.rdEx = 5'd8; v.rsId = {5'd8, 5'd1};
      tbl[6] = '{in: v, fu: 4'b0000, ctl: 7'b1101000};
      v.rdEx = 5'd9;
      tbl[7] = '{in: v, fu: 4'b0000, ctl: 7'b0};
      v = '0; v.loadEx = 1; v.ruwrEx = 1; v.rdEx = 5'd0; v.rsId = {5'd0, 5'd0};
      tbl[8] = '{in: v, fu: 4'b0000, ctl: 7'b0};
      v = '0; v.loadEx = 1; v.ruwrEx = 0; v.rdEx = 5'd6; v.rsId = {5'd2, 5'd6};
      tbl[9] = '{in: v, fu: 4'b0000, ctl: 7'b0};
      v.ruwrEx = 1; v.flush = 1;
      tbl[10] = '{in: v, fu: 4'b0000, ctl: 7'b0001100};
      v.flush = 0;
      tbl[11] = '{in: v, fu: 4'b0000, ctl: 7'b1101000};

      for (int i = 0; i < 12; i++)
         stepCheck($sformatf("table[%0d]", i), tbl[i].in, tbl[i].fu, tbl[i].ctl);

      // Multi-cycle op with a simultaneous load-use in T: MC stall wins.
      v = '0; v.mcStart = 1; v.loadEx = 1; v.ruwrEx = 1; v.rdEx = 5'd8; v.rsId = {5'd8, 5'd8};
      stepCheck("mc_T", v, 4'b0000, 7'b1110100);
      v = '0; v.mcStart = 1;
      stepCheck("mc_T+1", v, 4'b0000, 7'b1110110);
      stepCheck("mc_T+2", v, 4'b0000, 7'b1110110);
      stepCheck("mc_T+3_done", v, 4'b0000, 7'b0000011);
      v.mcStart = 0;
      stepCheck("mc_T+4_idle", v, 4'b0000, 7'b0);

      // Flush while busy: bubbles, no stall, back to IDLE without mc_done.
      v = '0; v.mcStart = 1;
      stepCheck("flush_T", v, 4'b0000, 7'b1110100);
      v.flush = 1;
      stepCheck("flush_T+1", v, 4'b0000, 7'b0001110);
      v = '0;
      stepCheck("flush_T+2", v, 4'b0000, 7'b0);
      stepCheck("flush_T+3", v, 4'b0000, 7'b0);

      // Reset pulse mid-BUSY clears outputs immediately.
      v = '0; v.mcStart = 1;
      stepCheck("rstbusy_T", v, 4'b0000, 7'b1110100);
      v.ruwrMe = 1; v.rdMe = 5'd2; v.rsEx = {5'd2, 5'd2};
      stepCheck("rstbusy_T+1", v, 4'b1010, 7'b1110110);
      #2;
      v.rst = 1;
      applyStimulus(v);
      #1;
      checkOutput("rstbusy_async", 4'b0000, 7'b0);
      v = '0;
      stepCheck("rstbusy_release", v, 4'b0000, 7'b0);
      stepCheck("rstbusy_no_done", v, 4'b0000, 7'b0);

      // Random phase against the reference model.
      k = 0;
      for (int n = 0; n < 3000; n++) begin
         v = '0;
         v.rst     = (n == 0) || ($urandom_range(0, 63) == 0);
         v.ruwrEx  = 1'($urandom_range(0, 1));
         v.loadEx  = 1'($urandom_range(0, 1));
         v.rdEx    = 5'($urandom_range(0, 3));
         v.mcStart = ($urandom_range(0, 5) == 0);
         v.ruwrMe  = 1'($urandom_range(0, 1));
         v.rdMe    = 5'($urandom_range(0, 3));
         v.ruwrWb  = 1'($urandom_range(0, 1));
         v.rdWb    = 5'($urandom_range(0, 3));
         v.rsId    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         v.rsEx    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         v.flush   = ($urandom_range(0, 15) == 0);
         if (v.rst) k = 0;
         stepCheck($sformatf("random[%0d]", n), v, modelFwd(v), modelCtl(v, k));
         @(posedge clk);
         k = modelNextK(v, k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Next-generation forwarding and hazard controller for the 5-stage segmented RISC-V core.
- Generalises ME/WB operand forwarding to NUM_SRC source operands and guards register x0.
- Adds load-use stall detection and a counter-driven stall FSM for multi-cycle EX operations (MUL/DIV).
- Sits beside the ID/EX, EX/ME and ME/WB pipeline registers and drives their hold and bubble controls plus the EX operand muxes.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of EX source operands (rs1, rs2, ...).
- MC_LAT, 4, EX occupancy in cycles of a multi-cycle operation; legal range 2..16.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- RUWr_ex  in  1  instruction in EX writes the register file.
- load_ex  in  1  instruction in EX is a load.
- rd_ex  in  REG_AW  EX destination register.
- mc_start_ex  in  1  instruction in EX is a multi-cycle operation.
- RUWr_me  in  1  ME writes the register file.
- rd_me  in  REG_AW  ME destination register.
- RUWr_wb  in  1  WB writes the register file.
- rd_wb  in  REG_AW  WB destination register.
- rs_id  in  NUM_SRC*REG_AW  ID source registers; operand i is at bits [i*REG_AW +: REG_AW].
- rs_ex  in  NUM_SRC*REG_AW  EX source registers, same packing as rs_id.
- flush  in  1  exception/redirect flush from ME.
- FUSrc  out  NUM_SRC*2  per-operand forward select; operand i is at bits [2i +: 2].
- stall_pc  out  1  hold the PC.
- stall_ifid  out  1  hold the IF/ID register.
- stall_idex  out  1  hold the ID/EX register.
- bubble_ex  out  1  load a NOP into ID/EX.
- bubble_me  out  1  load a NOP into EX/ME.
- mc_busy  out  1  multi-cycle FSM in BUSY.
- mc_done  out  1  final EX cycle of a multi-cycle operation.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-high (rst).
  - Reset puts the FSM in IDLE with cnt=0.
  - During reset all outputs are 0 and FUSrc=00 for every operand.
- Forwarding (combinational, per operand i):
  - Encoding: 00 = register file, 10 = ME, 11 = WB; 01 is never driven.
  - Select 10 if RUWr_me && rd_me!=0 && rd_me==rs_ex[i].
  - Otherwise select 11 if RUWr_wb && rd_wb!=0 && rd_wb==rs_ex[i].
  - Otherwise select 00.
  - ME has priority over WB. A rd of x0 never forwards.
- Load-use detection (combinational):
  - lu = load_ex && RUWr_ex && rd_ex!=0 && rd_ex equals any rs_id[i].
- Multi-cycle FSM: states IDLE and BUSY; counter cnt is 4 bits.
  - IDLE with mc_start_ex=1 (cycle T): assert stall_pc, stall_ifid, stall_idex and bubble_me; load cnt<=MC_LAT-2; go to BUSY.
  - BUSY with cnt!=0: keep the same four stalls asserted; cnt<=cnt-1.
  - BUSY with cnt==0: all stalls deasserted; mc_done=1; go to IDLE.
  - Result: exactly MC_LAT-1 stall cycles, with mc_done in cycle T+MC_LAT-1.
  - mc_start_ex is ignored while BUSY, because EX is held and the input stays high.
  - The multi-cycle unit captures its operands in cycle T, using the forwarding selects valid in T.
  - mc_busy=1 exactly while in BUSY.
- Output priority, highest first:
  1. flush:
     - All stall outputs are 0 and bubble_ex=bubble_me=1.
     - The FSM is forced to IDLE with cnt<=0; mc_done=0.
     - Any pending load-use is discarded.
  2. Multi-cycle stall (T or BUSY with cnt!=0): stalls as listed above; bubble_ex=0, so a load-use stall is not also applied.
  3. lu: stall_pc=stall_ifid=1, bubble_ex=1, stall_idex=0, bubble_me=0.
  4. Otherwise all controls are 0.
- A load-use stall lasts one cycle. The next cycle the load is in ME and forwarding covers the dependency.
- Reset asserted mid-BUSY returns the FSM to IDLE immediately and clears all outputs; no mc_done is produced.
- No other state is kept; forwarding and load-use logic have zero latency.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_ME=2'b10, FWD_WB=2'b11.
  - mc_state_t enum: MC_IDLE, MC_BUSY.
  - Constant REG_X0='0.
- Sub-module fwd_sel: one per-operand forwarding comparator, instantiated NUM_SRC times in a generate loop.

Test Plan:
- RUWr_me=1, rd_me=5, RUWr_wb=1, rd_wb=5, rs_ex={5,5} -> FUSrc={10,10}; change rd_me to 7 -> FUSrc={11,11}.
- RUWr_me=1, rd_me=0, rs_ex={0,3} -> FUSrc for both operands =00 (x0 guard).
- load_ex=1, RUWr_ex=1, rd_ex=8, rs_id[1]=8 -> one cycle with stall_pc=stall_ifid=bubble_ex=1; after rd_ex changes, all controls are 0.
- MC_LAT=4, mc_start_ex held high from cycle T -> stall_pc, stall_ifid, stall_idex and bubble_me asserted in cycles T..T+2; mc_done=1 and stalls 0 in T+3; mc_busy=1 in T+1..T+3.
- MC_LAT=4, flush=1 in T+1 -> bubble_ex=bubble_me=1, stalls 0, FSM IDLE in T+2 with no mc_done; rst pulse in BUSY -> immediate IDLE with all outputs 0.
- mc_start_ex and lu both true in cycle T -> multi-cycle stall outputs only, bubble_ex=0.
